// File: rtl/bp_resolve_unit_if.sv
// ============================================================================
// Module      : bp_resolve_unit_if
// Description : Push / resolve / update bundle of the branch-resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int GHR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push_valid_i;
    logic             push_ready_o;
    logic [XLEN-1:0]  push_pc_i;
    logic [XLEN-1:0]  push_target_i;
    logic             push_taken_i;
    logic             push_comp_i;
    logic [GHR_W-1:0] push_ghr_i;

    logic             res_valid_i;
    logic             res_taken_i;
    logic [XLEN-1:0]  res_target_i;
    logic             flush_i;

    logic             upd_valid_o;
    logic [XLEN-1:0]  upd_pc_o;
    logic             upd_taken_o;
    logic [GHR_W-1:0] upd_ghr_o;
    logic             mispred_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] count_o;
    logic             res_err_o;

    // Unit side: consumes fetch/execute requests, produces training/redirect.
    modport slave (
        input  push_valid_i, push_pc_i, push_target_i, push_taken_i,
               push_comp_i, push_ghr_i, res_valid_i, res_taken_i,
               res_target_i, flush_i,
        output push_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_ghr_o,
               mispred_o, redirect_pc_o, count_o, res_err_o
    );

    modport master (
        output push_valid_i, push_pc_i, push_target_i, push_taken_i,
               push_comp_i, push_ghr_i, res_valid_i, res_taken_i,
               res_target_i, flush_i,
        input  push_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_ghr_o,
               mispred_o, redirect_pc_o, count_o, res_err_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_resolve_unit.sv
// ============================================================================
// Module      : bp_resolve_unit
// Description : In-order queue of in-flight branch predictions; resolves the
//               oldest, emits predictor training and mispredict redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int GHR_W = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    bp_resolve_unit_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    // Entry storage, indexed by the wrapping read/write pointers.
    logic [XLEN-1:0]  r_pc_mem     [DEPTH];
    logic [XLEN-1:0]  r_target_mem [DEPTH];
    logic             r_taken_mem  [DEPTH];
    logic             r_comp_mem   [DEPTH];
    logic [GHR_W-1:0] r_ghr_mem    [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             r_upd_valid;
    logic [XLEN-1:0]  r_upd_pc;
    logic             r_upd_taken;
    logic [GHR_W-1:0] r_upd_ghr;
    logic             r_mispred;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_res_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push_acc;
    logic             w_res_acc;
    logic             w_res_err;
    logic             w_mispred;
    logic             w_store;
    logic [XLEN-1:0]  w_head_pc;
    logic [XLEN-1:0]  w_head_target;
    logic             w_head_taken;
    logic             w_head_comp;
    logic [GHR_W-1:0] w_head_ghr;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_redirect;
    logic [GHR_W-1:0] w_ghr_next;

    // Readiness depends on registered occupancy only: a same-cycle pop never
    // frees a slot for a push.
    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_acc = bus.push_valid_i && !w_full && !bus.flush_i;
    assign w_res_acc  = bus.res_valid_i && !w_empty && !bus.flush_i;
    assign w_res_err  = bus.res_valid_i && w_empty && !bus.flush_i;

    assign w_head_pc     = r_pc_mem[r_rd_ptr];
    assign w_head_target = r_target_mem[r_rd_ptr];
    assign w_head_taken  = r_taken_mem[r_rd_ptr];
    assign w_head_comp   = r_comp_mem[r_rd_ptr];
    assign w_head_ghr    = r_ghr_mem[r_rd_ptr];

    assign w_mispred = (bus.res_taken_i != w_head_taken) ||
                       (bus.res_taken_i && w_head_taken &&
                        (bus.res_target_i != w_head_target));

    assign w_seq_pc   = w_head_pc + (w_head_comp ? XLEN'(2) : XLEN'(4));
    assign w_redirect = bus.res_taken_i ? bus.res_target_i : w_seq_pc;
    // History shifts left; the oldest bit falls off, the outcome enters at LSB.
    assign w_ghr_next = (w_head_ghr << 1) | GHR_W'(bus.res_taken_i);

    // A push racing a mispredict belongs to the squashed path.
    assign w_store = w_push_acc && !(w_res_acc && w_mispred);

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_pc_mem[r_wr_ptr]     <= bus.push_pc_i;
            r_target_mem[r_wr_ptr] <= bus.push_target_i;
            r_taken_mem[r_wr_ptr]  <= bus.push_taken_i;
            r_comp_mem[r_wr_ptr]   <= bus.push_comp_i;
            r_ghr_mem[r_wr_ptr]    <= bus.push_ghr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush_i || (w_res_acc && w_mispred)) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_res_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_res_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_ghr     <= '0;
            r_mispred     <= 1'b0;
            r_redirect_pc <= '0;
            r_res_err     <= 1'b0;
        end else begin
            r_upd_valid <= w_res_acc;
            r_mispred   <= w_res_acc && w_mispred;
            if (w_res_acc) begin
                r_upd_pc      <= w_head_pc;
                r_upd_taken   <= bus.res_taken_i;
                r_upd_ghr     <= w_ghr_next;
                r_redirect_pc <= w_redirect;
            end
            if (w_res_err) begin
                r_res_err <= 1'b1;
            end
        end
    end

    assign bus.push_ready_o  = !w_full;
    assign bus.upd_valid_o   = r_upd_valid;
    assign bus.upd_pc_o      = r_upd_pc;
    assign bus.upd_taken_o   = r_upd_taken;
    assign bus.upd_ghr_o     = r_upd_ghr;
    assign bus.mispred_o     = r_mispred;
    assign bus.redirect_pc_o = r_redirect_pc;
    assign bus.count_o       = r_count;
    assign bus.res_err_o     = r_res_err;

endmodule

`default_nettype wire

// File: tb/tb_bp_resolve_unit.sv
// ============================================================================
// Module      : tb_bp_resolve_unit
// Description : Directed bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_resolve_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int GHR_W = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        comp;
        logic [7:0]  ghr;
    } ent_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ent_t        q[$];
    logic        exp_uv, exp_mp, exp_ut, exp_err;
    logic [31:0] exp_upc, exp_rd;
    logic [7:0]  exp_ghr;
    logic        chk_en;

    bp_resolve_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH), .GHR_W(GHR_W)) bus ();

    bp_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("count",    32'(bus.count_o),      32'(q.size()));
            chk("ready",    32'(bus.push_ready_o), 32'(q.size() != DEPTH));
            chk("upd_v",    32'(bus.upd_valid_o),  32'(exp_uv));
            chk("mispred",  32'(bus.mispred_o),    32'(exp_mp));
            chk("upd_pc",   bus.upd_pc_o,          exp_upc);
            chk("upd_tk",   32'(bus.upd_taken_o),  32'(exp_ut));
            chk("upd_ghr",  32'(bus.upd_ghr_o),    32'(exp_ghr));
            chk("redirect", bus.redirect_pc_o,     exp_rd);
            chk("res_err",  32'(bus.res_err_o),    32'(exp_err));
        end
    end

    task automatic idle_inputs();
        bus.push_valid_i  = 1'b0;
        bus.push_pc_i     = '0;
        bus.push_target_i = '0;
        bus.push_taken_i  = 1'b0;
        bus.push_comp_i   = 1'b0;
        bus.push_ghr_i    = '0;
        bus.res_valid_i   = 1'b0;
        bus.res_taken_i   = 1'b0;
        bus.res_target_i  = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_uv = 0; exp_mp = 0; exp_ut = 0; exp_err = 0;
        exp_upc = '0; exp_rd = '0; exp_ghr = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, return #1 after the edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic [31:0] ptgt,
                        input logic ptk, input logic pcomp, input logic [7:0] pghr,
                        input logic rv, input logic rtk, input logic [31:0] rtgt,
                        input logic fl);
        ent_t        e;
        ent_t        n;
        logic        racc, pacc, mis;
        logic        n_uv, n_mp, n_ut, n_err;
        logic [31:0] n_upc, n_rd;
        logic [7:0]  n_ghr;
        bus.push_valid_i  = pv;   bus.push_pc_i   = ppc;  bus.push_target_i = ptgt;
        bus.push_taken_i  = ptk;  bus.push_comp_i = pcomp; bus.push_ghr_i   = pghr;
        bus.res_valid_i   = rv;   bus.res_taken_i = rtk;  bus.res_target_i  = rtgt;
        bus.flush_i       = fl;
        n_uv = 0; n_mp = 0; n_ut = exp_ut; n_err = exp_err;
        n_upc = exp_upc; n_rd = exp_rd; n_ghr = exp_ghr;
        n.pc = ppc; n.target = ptgt; n.taken = ptk; n.comp = pcomp; n.ghr = pghr;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            racc = rv && (q.size() != 0);
            pacc = pv && (q.size() < DEPTH);
            if (rv && q.size() == 0) n_err = 1;
            mis = 0;
            if (racc) begin
                e = q.pop_front();
                mis = (rtk != e.taken) || (rtk && rtgt != e.target);
                n_uv  = 1;
                n_mp  = mis;
                n_upc = e.pc;
                n_ut  = rtk;
                n_ghr = {e.ghr[6:0], rtk};
                n_rd  = rtk ? rtgt : e.pc + (e.comp ? 32'd2 : 32'd4);
            end
            if (mis) q.delete();
            else if (pacc) q.push_back(n);
        end
        exp_uv = n_uv; exp_mp = n_mp; exp_ut = n_ut; exp_err = n_err;
        exp_upc = n_upc; exp_rd = n_rd; exp_ghr = n_ghr;
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic comp, input logic [7:0] ghr);
        step(1, pc, tgt, tk, comp, ghr, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 0, 1, tk, tgt, 0);
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #22;
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_ready", 32'(bus.push_ready_o), 1);
        chk("rst_updv",  32'(bus.upd_valid_o), 0);
        chk("rst_err",   32'(bus.res_err_o), 0);
        rst_n = 1'b1;
        chk_en = 1;
        @(posedge clk); #1;

        // Correct not-taken prediction
        push(32'h1000, 32'h0, 0, 0, 8'h00);
        resolve(0, 32'h0);
        chk("a_updv", 32'(bus.upd_valid_o), 1);
        chk("a_pc",   bus.upd_pc_o, 32'h1000);
        chk("a_mp",   32'(bus.mispred_o), 0);
        chk("a_cnt",  32'(bus.count_o), 0);

        // Direction mispredict: not-taken predicted, taken resolved
        push(32'h1000, 32'h0, 0, 0, 8'h5A);
        resolve(1, 32'h2000);
        chk("b_mp",  32'(bus.mispred_o), 1);
        chk("b_rd",  bus.redirect_pc_o, 32'h2000);
        chk("b_ghr", 32'(bus.upd_ghr_o), 32'hB5);

        // Compressed taken predicted, resolved not-taken / wrong target / correct
        push(32'h3000, 32'h4000, 1, 1, 8'h00);
        resolve(0, 32'h0);
        chk("c_mp", 32'(bus.mispred_o), 1);
        chk("c_rd", bus.redirect_pc_o, 32'h3002);
        push(32'h3000, 32'h4000, 1, 1, 8'h00);
        resolve(1, 32'h4400);
        chk("d_mp", 32'(bus.mispred_o), 1);
        chk("d_rd", bus.redirect_pc_o, 32'h4400);
        push(32'h3000, 32'h4000, 1, 0, 8'h81);
        resolve(1, 32'h4000);
        chk("e_mp", 32'(bus.mispred_o), 0);

        // Fill, overflow, full push+pop, drain in order
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 0, 0, 0, 8'(i));
        chk("f_ready", 32'(bus.push_ready_o), 0);
        push(32'h110, 0, 0, 0, 8'h00);
        chk("f_cnt4", 32'(bus.count_o), 4);
        step(1, 32'h114, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("f_pc0",  bus.upd_pc_o, 32'h100);
        chk("f_cnt3", 32'(bus.count_o), 3);
        for (int i = 1; i < 4; i++) begin
            resolve(0, 0);
            chk("f_order", bus.upd_pc_o, 32'h100 + 32'(4 * i));
        end

        // Pointer wrap with back-to-back push/resolve pairs
        push(32'h200, 0, 0, 0, 8'h11);
        for (int i = 1; i <= 6; i++)
            step(1, 32'h200 + 32'(4 * i), 0, 0, 0, 8'(i), 1, 0, 0, 0);
        resolve(0, 0);
        chk("g_last", bus.upd_pc_o, 32'h218);

        // Mispredict squashes younger entries and a concurrent push
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 0, 0, 0, 8'h0);
        step(1, 32'h600, 0, 0, 0, 0, 1, 1, 32'h700, 0);
        chk("h_cnt", 32'(bus.count_o), 0);
        resolve(0, 0);
        chk("h_err",  32'(bus.res_err_o), 1);
        chk("h_updv", 32'(bus.upd_valid_o), 0);

        // Flush dominates push and resolve
        push(32'h800, 0, 0, 0, 0);
        push(32'h804, 0, 0, 0, 0);
        step(1, 32'h808, 0, 0, 0, 0, 1, 0, 0, 1);
        chk("i_cnt",  32'(bus.count_o), 0);
        chk("i_updv", 32'(bus.upd_valid_o), 0);

        // Asynchronous reset mid-operation with a pending update pulse
        for (int i = 0; i < 3; i++) push(32'h900 + 32'(4 * i), 0, 0, 0, 0);
        resolve(0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("r_cnt",   32'(bus.count_o), 0);
        chk("r_ready", 32'(bus.push_ready_o), 1);
        chk("r_updv",  32'(bus.upd_valid_o), 0);
        chk("r_pc",    bus.upd_pc_o, 0);
        chk("r_rd",    bus.redirect_pc_o, 0);
        chk("r_err",   32'(bus.res_err_o), 0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push(32'hA00, 0, 0, 0, 0);
        resolve(0, 0);
        chk("s_pc", bus.upd_pc_o, 32'hA00);
        @(posedge clk); #1;
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bp_resolve_unit.md
BP_RESOLVE_UNIT -- requirements
Module: bp_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, data/address width.
REQ-002 SHALL have parameter DEPTH, 4, in-flight prediction entries (power of 2, >=2).
REQ-003 SHALL have parameter GHR_W, 8, global history snapshot width.
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port push_valid_i  in  1  fetch issued a predicted control-flow instruction.
REQ-007 SHALL have port push_ready_o  out  1  queue can accept a push.
REQ-008 SHALL have ports push_pc_i / push_target_i  in  XLEN each  instruction PC / predicted target.
REQ-009 SHALL have ports push_taken_i  in  1  predicted direction; push_comp_i  in  1  compressed instruction.
REQ-010 SHALL have port push_ghr_i  in  GHR_W  history snapshot at prediction time.
REQ-011 SHALL have port res_valid_i  in  1  execute resolves the oldest entry.
REQ-012 SHALL have ports res_taken_i  in  1 / res_target_i  in  XLEN  actual direction / target.
REQ-013 SHALL have port flush_i  in  1  external pipeline flush.
REQ-014 SHALL have ports upd_valid_o 1, upd_pc_o XLEN, upd_taken_o 1, upd_ghr_o GHR_W  out  predictor training update.
REQ-015 SHALL have ports mispred_o  out  1  and redirect_pc_o  out  XLEN  fetch redirect.
REQ-016 SHALL have ports count_o  out  $clog2(DEPTH)+1  occupancy; res_err_o  out  1  sticky protocol error.

Function
REQ-017 SHALL store entries {pc, taken, target, comp, ghr} in FIFO order; pointers wrap modulo DEPTH.
REQ-018 SHALL drive push_ready_o = (count != DEPTH), registered-state only; no full-bypass via same-cycle pop.
REQ-019 SHALL accept a push when push_valid_i && push_ready_o; push while full is dropped, state unchanged.
REQ-020 SHALL accept a resolve when res_valid_i && count != 0; it pops the oldest entry.
REQ-021 SHALL flag mispredict when res_taken_i != entry.taken, or both taken and res_target_i != entry.target.
REQ-022 SHALL register outputs one cycle after an accepted resolve: upd_valid_o=1, upd_pc_o=entry.pc, upd_taken_o=res_taken_i, upd_ghr_o={entry.ghr[GHR_W-2:0], res_taken_i}.
REQ-023 SHALL in the same cycle as REQ-022 set mispred_o=1 iff mispredict; redirect_pc_o = res_taken_i ? res_target_i : entry.pc + (entry.comp ? 2 : 4), modulo 2^XLEN.
REQ-024 SHALL make upd_valid_o and mispred_o single-cycle pulses; redirect_pc_o holds its last value otherwise.
REQ-025 SHALL on mispredict discard all younger entries: count_o = 0 next cycle; a push in that same cycle is not stored.
REQ-026 SHALL on simultaneous accepted push and non-mispredicting resolve keep count unchanged and store the push.
REQ-027 SHALL on flush_i clear queue (count 0) next cycle, dominating push and resolve; no upd/mispred pulse results.
REQ-028 SHALL ignore res_valid_i on empty queue (no pulse) and set res_err_o=1, held until reset.
REQ-029 SHALL keep count_o equal to the number of stored entries at all times.

Reset
REQ-030 SHALL on rst_ni low immediately clear pointers, count_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_ghr_o, mispred_o, redirect_pc_o, res_err_o to 0; push_ready_o reads 1.
REQ-031 SHALL on reset mid-operation discard all entries and suppress any pending pulse.

Verification
REQ-032 Push pc=0x1000 taken=0 comp=0, then resolve taken=0 -> next cycle upd_valid_o=1, upd_pc_o=0x1000, upd_taken_o=0, mispred_o=0, count_o=0.
REQ-033 Push pc=0x1000 taken=0 ghr=0x5A, resolve taken=1 target=0x2000 -> mispred_o=1, redirect_pc_o=0x2000, upd_ghr_o=0xB5.
REQ-034 Push pc=0x3000 taken=1 target=0x4000 comp=1, resolve taken=0 -> mispred_o=1, redirect_pc_o=0x3002; taken with target=0x4400 -> redirect 0x4400.
REQ-035 DEPTH=4: push 4 -> push_ready_o=0, 5th push dropped; resolve all correctly -> upd_pc_o in push order; 6 further push/resolve pairs exercise pointer wrap.
REQ-036 3 entries, oldest mispredicts with simultaneous push -> count_o=0 next cycle; then resolve on empty -> res_err_o=1, no pulse.
REQ-037 flush_i with simultaneous push and resolve -> count_o=0, no upd_valid_o; rst_ni low with 2 entries -> all outputs 0 asynchronously.
